// File: rtl/serial_fa_cell.sv
// Single-bit full adder; the only arithmetic in the serial adder datapath.
module serial_fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ cin;
    assign co = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop, LSB first.
// Result is published only on the RUN->DONE edge, with a one-cycle done pulse.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int             CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    logic [1:0]       state_reg;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-1:0] res_reg;
    logic             carry_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg;

    logic             fa_s;
    logic             fa_co;
    logic [WIDTH-1:0] res_next;

    serial_fa_cell u_fa (
        .a   (a_sh_reg[0]),
        .b   (b_sh_reg[0]),
        .cin (carry_reg),
        .s   (fa_s),
        .co  (fa_co)
    );

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 lands in place.
    assign res_next = (res_reg >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            a_sh_reg  <= '0;
            b_sh_reg  <= '0;
            res_reg   <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_sh_reg  <= a;
                        b_sh_reg  <= b;
                        carry_reg <= cin;
                        cnt_reg   <= '0;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    res_reg   <= res_next;
                    carry_reg <= fa_co;
                    a_sh_reg  <= a_sh_reg >> 1;
                    b_sh_reg  <= b_sh_reg >> 1;
                    if (cnt_reg == LAST) begin
                        cnt_reg   <= '0;
                        sum_reg   <= res_next;
                        cout_reg  <= fa_co;
                        state_reg <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign ready = (state_reg == IDLE);
    assign busy  = (state_reg == RUN);
    assign done  = (state_reg == DONE);
    assign sum   = sum_reg;
    assign cout  = cout_reg;
endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: WIDTH=8 and WIDTH=1 instances checked every cycle
// against a cycles-remaining reference model, plus directed literal cases.
module tb_serial_adder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start8, cin8, ready8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start1, cin1, ready1, busy1, done1, cout1;
    logic [0:0] a1, b1, sum1;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .ready(ready8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .ready(ready1), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: cycles remaining until the block is idle again.
    // W+1 right after acceptance, 1 during the done cycle, 0 when idle.
    int         rem8 = 0;
    int         rem1 = 0;
    logic [8:0] pend8 = '0, res8 = '0;
    logic [1:0] pend1 = '0, res1 = '0;

    always @(posedge clk or posedge rst) begin
        cyc++;
        if (rst) begin
            rem8 = 0; res8 = '0;
            rem1 = 0; res1 = '0;
        end else begin
            if (rem8 == 0) begin
                if (start8) begin rem8 = 9; pend8 = a8 + b8 + cin8; end
            end else begin
                rem8--;
                if (rem8 == 1) res8 = pend8;
            end
            if (rem1 == 0) begin
                if (start1) begin rem1 = 2; pend1 = a1 + b1 + cin1; end
            end else begin
                rem1--;
                if (rem1 == 1) res1 = pend1;
            end
        end
    end

    always @(negedge clk) begin
        chk("w8_ready", ready8, rem8 == 0);
        chk("w8_busy",  busy8,  rem8 > 1);
        chk("w8_done",  done8,  rem8 == 1);
        chk("w8_sum",   sum8,   res8[7:0]);
        chk("w8_cout",  cout8,  res8[8]);
        chk("w1_ready", ready1, rem1 == 0);
        chk("w1_busy",  busy1,  rem1 > 1);
        chk("w1_done",  done1,  rem1 == 1);
        chk("w1_sum",   sum1,   res1[0]);
        chk("w1_cout",  cout1,  res1[1]);
    end

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                       input logic [7:0] es, input logic ec,
                       input bit chk_hold, input logic [7:0] hold, input string nm);
        int lat;
        @(negedge clk);
        a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        lat = 1;
        while (!done8 && lat < 40) begin
            if (chk_hold) chk({nm, "_hold"}, sum8, hold);
            @(negedge clk);
            lat++;
        end
        chk({nm, "_latency"}, lat, 9);
        chk({nm, "_sum"}, sum8, es);
        chk({nm, "_cout"}, cout8, ec);
        @(negedge clk);
        chk({nm, "_ready_after"}, ready8, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int ndone, k, last_done;
        logic [7:0] got_sum;
        logic       got_cout;

        rst = 1'b1;
        start8 = 0; a8 = 0; b8 = 0; cin8 = 0;
        start1 = 0; a1 = 0; b1 = 0; cin1 = 0;
        repeat (3) @(negedge clk);
        chk("rst_init_ready", ready8, 1'b1);
        chk("rst_init_sum", sum8, 8'h00);
        #2 rst = 1'b0;

        op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, "ff_01");
        op8(8'h5A, 8'hA5, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, "5a_a5");
        op8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b1, 8'h00, "12_34");

        // Start pulse and operand churn during RUN must be ignored.
        @(negedge clk);
        a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'($urandom); cin8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
        ndone = 0; got_sum = 8'hxx; got_cout = 1'bx;
        repeat (12) begin
            @(negedge clk);
            if (done8) begin ndone++; got_sum = sum8; got_cout = cout8; end
        end
        chk("ignore_done_count", ndone, 1);
        chk("ignore_sum", got_sum, 8'h10);
        chk("ignore_cout", got_cout, 1'b0);

        // Asynchronous reset three cycles into RUN, after a nonzero result.
        @(negedge clk);
        a8 = 8'hF0; b8 = 8'h33; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_ready", ready8, 1'b1);
        chk("rst_mid_busy", busy8, 1'b0);
        chk("rst_mid_done", done8, 1'b0);
        chk("rst_mid_sum", sum8, 8'h00);
        chk("rst_mid_cout", cout8, 1'b0);
        #1 rst = 1'b0;
        op8(8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0, 8'h00, "after_rst");

        // WIDTH=1: all operand combinations, start held high back-to-back.
        start1 = 1'b1;
        last_done = 0;
        for (int i = 0; i < 8; i++) begin
            k = 0;
            while (!ready1 && k < 10) begin @(negedge clk); k++; end
            chk("w1_ready_timeout", k < 10, 1'b1);
            a1 = 1'(i >> 2); b1 = 1'(i >> 1); cin1 = 1'(i);
            @(negedge clk);
            k = 0;
            while (!done1 && k < 10) begin @(negedge clk); k++; end
            chk("w1_done_timeout", k < 10, 1'b1);
            chk("w1_combo", {cout1, sum1}, ((i >> 2) & 1) + ((i >> 1) & 1) + (i & 1));
            if (i > 0) chk("w1_period", cyc - last_done, 3);
            last_done = cyc;
        end
        @(negedge clk);
        start1 = 1'b0;

        // Randomized traffic on both instances, with occasional async resets.
        for (int n = 0; n < 800; n++) begin
            @(negedge clk);
            start8 = ($urandom_range(0, 3) != 0);
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            start1 = ($urandom_range(0, 2) != 0);
            a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
            if ($urandom_range(0, 149) == 0) begin
                #2 rst = 1'b1;
                #1 rst = 1'b0;
            end
        end
        start8 = 1'b0; start1 = 1'b0;
        repeat (12) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
